sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

- Sits between the CPU core and the SoC AXI3 interconnect.
- Converts the core's two SRAM-like request/response ports (instruction and data) into a single AXI3 master, one beat per transaction.
- At most one outstanding read and one outstanding write at a time.
- Arbitrates reads between the instruction and data ports, with data priority.
- Returns responses with registered one-cycle `data_ok` pulses.

## Interface
Parameters:
- INST_ID, default 4'd0: ARID used for instruction-port reads.
- DATA_ID, default 4'd1: ARID/AWID/WID used for data-port accesses.

Ports (`x` = `inst` or `data`):
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- x_sram_req  in  1  request valid; held until `addr_ok`.
- x_sram_wr  in  1  1 = write, 0 = read. `inst_sram_wr` is ignored and treated as 0.
- x_sram_size  in  2  0 = byte, 1 = half, 2 = word.
- x_sram_addr  in  32  byte address.
- x_sram_wstrb  in  4  byte enables (writes only).
- x_sram_wdata  in  32  write data.
- x_sram_addr_ok  out  1  request accepted this cycle (req & addr_ok).
- x_sram_data_ok  out  1  one-cycle response pulse.
- x_sram_rdata  out  32  read data; valid while `data_ok` is high.
- arid/araddr/arsize/arvalid  out  4/32/3/1  AR channel.
- arready  in  1  AR channel ready.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel.
- rready  out  1  R channel ready.
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AW channel.
- awready  in  1  AW channel ready.
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  W channel.
- wready  in  1  W channel ready.
- bid/bresp/bvalid  in  4/2/1  B channel.
- bready  out  1  B channel ready.
- Tied-off AR/AW fields: arlen/awlen = 0, arburst/awburst = 2'b01, arlock/awlock = 0, arcache/awcache = 0, arprot/awprot = 0, wlast = 1.

## Operation
Read FSM:
- States: R_IDLE → R_AR → R_R → R_IDLE.
- In R_IDLE, a read is eligible as follows:
  - Data read: `data_sram_req & ~data_sram_wr` and the write FSM is in W_IDLE (read-after-write safety).
  - Instruction read: `inst_sram_req`.
- If both are eligible, data wins.
- Selected port sees `addr_ok` = 1 combinationally.
- On the accepting edge:
  - Latch `araddr` = addr, `arsize` = {1'b0, size}, `arid` = port ID.
  - Go to R_AR with `arvalid` = 1.
- R_AR: on `arvalid & arready`, drop `arvalid` and go to R_R with `rready` = 1.
- R_R: on `rvalid & rready`:
  - Register `rdata`.
  - Go to R_IDLE with `rready` = 0.
  - Next cycle, pulse `data_ok` on the port whose ID matches the latched `arid`. `rid` and `rresp` are ignored.

Write FSM:
- States: W_IDLE → W_REQ → W_B → W_IDLE.
- In W_IDLE, accept `data_sram_req & data_sram_wr` only when the read FSM holds no data-port read (R_IDLE, or busy with an instruction read).
- On acceptance, `data_sram_addr_ok` = 1, and:
  - Latch `awaddr` = addr and `awsize` = {1'b0, size}.
  - Latch `wdata` and `wstrb`.
  - Assert `awvalid` and `wvalid` together.
- W_REQ: `awvalid` and `wvalid` each drop independently on their own handshake. Leave W_REQ once both have completed, possibly in different cycles; then go to W_B with `bready` = 1.
- W_B: on `bvalid & bready`, `bready` = 0, go to W_IDLE, and pulse `data_sram_data_ok` next cycle. `bresp` is ignored.

Data-port arbitration:
- A data request is accepted by exactly one FSM per cycle.
- The interlocks guarantee that read and write `data_ok` never coincide on the data port.
- `data_sram_addr_ok` = 0 whenever the data request is not eligible.

Instruction reads:
- May overlap an outstanding write.

## Timing
- Reset (synchronous, active-high, highest priority) forces:
  - Both FSMs to IDLE.
  - `arvalid`, `awvalid`, `wvalid`, `rready`, `bready` = 0.
  - `data_ok` = 0 on both ports.
  - `rdata` and all latched address/ID/data registers = 0.
- Reset mid-transaction abandons it with no response pulse.
- Minimum read latency with `arready` and `rvalid` same-cycle:
  - Cycle 0: accept.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: `data_ok`.
- Minimum write latency: accept at 0, AW+W at 1, B at 2, `data_ok` at 3.
- A new request may be accepted in the same cycle `data_ok` pulses, since the FSM is already back in IDLE.
- All AXI valid signals stay high until their handshake and never drop early. AR and AW payloads stay stable while their valid is high.
- `addr_ok` is combinational from `req` and FSM state. It is never asserted without `req`.

## Test plan
- Instruction read of 0x1C000000, `arready` = 1, `rvalid` with rdata 0x02800C0C two cycles later → arid = 0, arsize = 2, `inst_sram_data_ok` pulses one cycle after the R handshake with rdata 0x02800C0C.
- Simultaneous inst and data reads (data addr 0x0000_1000) → data accepted first (arid = 1); inst `addr_ok` = 0 until R_IDLE, then inst accepted (arid = 0).
- Data write, addr 0x1004, wstrb 4'b0011, size 1, `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` after 3; `bready` only after both; `data_ok` follows B by one cycle.
- Data write outstanding, then data read of the same address → data read `addr_ok` held 0 until W_IDLE. An instruction read issued meanwhile proceeds.
- Back-to-back instruction reads with `req` held high → second accepted in the cycle the first `data_ok` pulses; no extra idle cycle.
- Reset asserted in R_R and in W_REQ → next cycle all valid/ready signals and `data_ok` = 0, FSMs IDLE; a late `rvalid` produces no `data_ok`.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// SRAM-like inst/data ports to a single-beat AXI3 master.
// One outstanding read and one outstanding write; data reads win arbitration.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } wr_state_t;

    rd_state_t   r_rst;
    rd_state_t   w_rst_nxt;
    wr_state_t   r_wst;
    wr_state_t   w_wst_nxt;

    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [2:0]  r_arsize;
    logic        r_rd_data;
    logic [31:0] r_rdata;
    logic        r_inst_ok;
    logic        r_data_rok;
    logic [31:0] r_awaddr;
    logic [2:0]  r_awsize;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_data_wok;

    logic        w_rd_idle;
    logic        w_wr_idle;
    logic        w_data_rd;
    logic        w_inst_rd;
    logic        w_data_wr;
    logic        w_r_hs;
    logic        w_b_hs;
    logic        w_aw_nxt;
    logic        w_w_nxt;
    logic        w_unused;

    assign w_rd_idle = (r_rst == R_IDLE);
    assign w_wr_idle = (r_wst == W_IDLE);

    // Data reads wait for the write side to drain so they never pass a write.
    assign w_data_rd = data_sram_req & ~data_sram_wr & w_rd_idle & w_wr_idle;
    assign w_inst_rd = inst_sram_req & w_rd_idle & ~w_data_rd;
    assign w_data_wr = data_sram_req & data_sram_wr & w_wr_idle
                     & ~(~w_rd_idle & r_rd_data);

    assign w_r_hs = (r_rst == R_R) & rvalid;
    assign w_b_hs = (r_wst == W_B) & bvalid;

    always_comb begin
        w_rst_nxt = r_rst;
        unique case (r_rst)
            R_IDLE:  if (w_data_rd | w_inst_rd) w_rst_nxt = R_AR;
            R_AR:    if (arready) w_rst_nxt = R_R;
            R_R:     if (rvalid) w_rst_nxt = R_IDLE;
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wst_nxt = r_wst;
        w_aw_nxt  = r_awvalid;
        w_w_nxt   = r_wvalid;
        unique case (r_wst)
            W_IDLE: begin
                if (w_data_wr) begin
                    w_wst_nxt = W_REQ;
                    w_aw_nxt  = 1'b1;
                    w_w_nxt   = 1'b1;
                end
            end
            W_REQ: begin
                w_aw_nxt = r_awvalid & ~awready;
                w_w_nxt  = r_wvalid & ~wready;
                if (!w_aw_nxt && !w_w_nxt) w_wst_nxt = W_B;
            end
            W_B:     if (bvalid) w_wst_nxt = W_IDLE;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst      <= R_IDLE;
            r_wst      <= W_IDLE;
            r_arid     <= '0;
            r_araddr   <= '0;
            r_arsize   <= '0;
            r_rd_data  <= 1'b0;
            r_rdata    <= '0;
            r_inst_ok  <= 1'b0;
            r_data_rok <= 1'b0;
            r_awaddr   <= '0;
            r_awsize   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_data_wok <= 1'b0;
        end else begin
            r_rst     <= w_rst_nxt;
            r_wst     <= w_wst_nxt;
            r_awvalid <= w_aw_nxt;
            r_wvalid  <= w_w_nxt;
            if (w_data_rd) begin
                r_arid    <= DATA_ID;
                r_araddr  <= data_sram_addr;
                r_arsize  <= {1'b0, data_sram_size};
                r_rd_data <= 1'b1;
            end else if (w_inst_rd) begin
                r_arid    <= INST_ID;
                r_araddr  <= inst_sram_addr;
                r_arsize  <= {1'b0, inst_sram_size};
                r_rd_data <= 1'b0;
            end
            if (w_r_hs) r_rdata <= rdata;
            r_data_rok <= w_r_hs & (r_arid == DATA_ID);
            r_inst_ok  <= w_r_hs & (r_arid == INST_ID) & (r_arid != DATA_ID);
            if (w_data_wr) begin
                r_awaddr <= data_sram_addr;
                r_awsize <= {1'b0, data_sram_size};
                r_wdata  <= data_sram_wdata;
                r_wstrb  <= data_sram_wstrb;
            end
            r_data_wok <= w_b_hs;
        end
    end

    assign inst_sram_addr_ok = w_inst_rd;
    assign inst_sram_data_ok = r_inst_ok;
    assign inst_sram_rdata   = r_rdata;
    assign data_sram_addr_ok = w_data_rd | w_data_wr;
    assign data_sram_data_ok = r_data_rok | r_data_wok;
    assign data_sram_rdata   = r_rdata;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = 4'd0;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_rst == R_AR);
    assign rready  = (r_rst == R_R);

    assign awid    = DATA_ID;
    assign awaddr  = r_awaddr;
    assign awlen   = 4'd0;
    assign awsize  = r_awsize;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = r_awvalid;
    assign wid     = DATA_ID;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = (r_wst == W_B);

    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                        rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with per-port response scoreboards.
// The bench plays the AXI slave by hand, cycle by cycle.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  rid, bid;

    typedef struct packed {
        logic        wr;
        logic [31:0] d;
    } exp_t;

    exp_t q_inst[$];
    exp_t q_data[$];
    exp_t e_i, e_d;
    int total = 0;
    int bad = 0;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Responses are popped in order per port when data_ok is seen.
    always @(negedge clk) begin
        if (inst_sram_data_ok) begin
            if (q_inst.size() == 0) begin
                chk("inst_unexpected_ok", inst_sram_data_ok, 0);
            end else begin
                e_i = q_inst.pop_front();
                chk("inst_rdata", inst_sram_rdata, e_i.d);
            end
        end
        if (data_sram_data_ok) begin
            if (q_data.size() == 0) begin
                chk("data_unexpected_ok", data_sram_data_ok, 0);
            end else begin
                e_d = q_data.pop_front();
                if (!e_d.wr) chk("data_rdata", data_sram_rdata, e_d.d);
                else chk("data_wr_ok", data_sram_data_ok, 1);
            end
        end
    end

    task automatic serve_r(input logic [3:0] id, input logic [31:0] addr,
                           input logic [2:0] sz, input logic [31:0] d);
        for (int i = 0; i < 20 && !arvalid; i++) cyc();
        chk("arvalid_seen", arvalid, 1);
        chk("arid", arid, id);
        chk("araddr", araddr, addr);
        chk("arsize", arsize, sz);
        cyc();
        chk("rready_up", rready, 1);
        chk("arvalid_down", arvalid, 0);
        rvalid = 1'b1;
        rdata  = d;
        cyc();
        rvalid = 1'b0;
        rdata  = '0;
        chk("rready_down", rready, 0);
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
        inst_sram_addr = '0; inst_sram_wstrb = '0; inst_sram_wdata = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
        data_sram_addr = '0; data_sram_wstrb = '0; data_sram_wdata = '0;
        arready = 1; rid = 0; rdata = '0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 1; bresp = 0; bvalid = 0;
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_inst_ok", inst_sram_data_ok, 0);
        chk("rst_data_ok", data_sram_data_ok, 0);
        chk("tie_arburst", arburst, 2'b01);
        chk("tie_wlast", wlast, 1);

        // single instruction read
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
        #1;
        chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t1_data_addr_ok", data_sram_addr_ok, 0);
        q_inst.push_back('{wr: 1'b0, d: 32'h0280_0C0C});
        cyc();
        inst_sram_req = 0;
        serve_r(4'd0, 32'h1C00_0000, 3'd2, 32'h0280_0C0C);
        chk("t1_ok_pulse", inst_sram_data_ok, 1);
        cyc();
        chk("t1_ok_single", inst_sram_data_ok, 0);

        // simultaneous reads: data first
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0004;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000;
        #1;
        chk("t2_data_addr_ok", data_sram_addr_ok, 1);
        chk("t2_inst_blocked", inst_sram_addr_ok, 0);
        q_data.push_back('{wr: 1'b0, d: 32'hAAAA_0001});
        q_inst.push_back('{wr: 1'b0, d: 32'hBBBB_0002});
        cyc();
        data_sram_req = 0;
        chk("t2_inst_busy", inst_sram_addr_ok, 0);
        serve_r(4'd1, 32'h0000_1000, 3'd2, 32'hAAAA_0001);
        chk("t2_inst_now_ok", inst_sram_addr_ok, 1);
        cyc();
        inst_sram_req = 0;
        serve_r(4'd0, 32'h1C00_0004, 3'd2, 32'hBBBB_0002);
        cyc();

        // data write, awready late, wready immediate
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd1;
        data_sram_addr = 32'h0000_1004; data_sram_wstrb = 4'b0011;
        data_sram_wdata = 32'h0000_BEEF;
        awready = 0; wready = 1;
        #1;
        chk("t3_addr_ok", data_sram_addr_ok, 1);
        q_data.push_back('{wr: 1'b1, d: 32'h0});
        cyc();
        data_sram_req = 0;
        chk("t3_awvalid0", awvalid, 1);
        chk("t3_wvalid0", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h0000_1004);
        chk("t3_awsize", awsize, 3'd1);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_wdata", wdata, 32'h0000_BEEF);
        chk("t3_awid", awid, 4'd1);
        chk("t3_wid", wid, 4'd1);
        cyc();
        chk("t3_wvalid1", wvalid, 0);
        chk("t3_awvalid1", awvalid, 1);
        chk("t3_bready1", bready, 0);
        cyc();
        chk("t3_awvalid2", awvalid, 1);
        chk("t3_bready2", bready, 0);
        awready = 1;
        cyc();
        awready = 0;
        chk("t3_awvalid3", awvalid, 0);
        chk("t3_bready3", bready, 1);
        bvalid = 1;
        cyc();
        bvalid = 0;
        chk("t3_bready_down", bready, 0);
        chk("t3_data_ok", data_sram_data_ok, 1);
        cyc();

        // read-after-write hold; instruction read overlaps the write
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2;
        data_sram_addr = 32'h0000_1004; data_sram_wstrb = 4'hF;
        data_sram_wdata = 32'h1234_5678;
        awready = 0; wready = 0;
        #1;
        chk("t4_wr_addr_ok", data_sram_addr_ok, 1);
        q_data.push_back('{wr: 1'b1, d: 32'h0});
        cyc();
        data_sram_wr = 0;
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0010;
        #1;
        chk("t4_rd_held", data_sram_addr_ok, 0);
        chk("t4_inst_go", inst_sram_addr_ok, 1);
        q_inst.push_back('{wr: 1'b0, d: 32'h1111_2222});
        cyc();
        inst_sram_req = 0;
        serve_r(4'd0, 32'h1C00_0010, 3'd2, 32'h1111_2222);
        chk("t4_rd_held2", data_sram_addr_ok, 0);
        awready = 1; wready = 1;
        cyc();
        awready = 0; wready = 0;
        chk("t4_bready", bready, 1);
        chk("t4_rd_held3", data_sram_addr_ok, 0);
        bvalid = 1;
        cyc();
        bvalid = 0;
        chk("t4_rd_released", data_sram_addr_ok, 1);
        q_data.push_back('{wr: 1'b0, d: 32'h5555_6666});
        cyc();
        data_sram_req = 0;
        serve_r(4'd1, 32'h0000_1004, 3'd2, 32'h5555_6666);
        cyc();

        // back-to-back instruction reads
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0020;
        q_inst.push_back('{wr: 1'b0, d: 32'hCAFE_0001});
        cyc();
        serve_r(4'd0, 32'h1C00_0020, 3'd2, 32'hCAFE_0001);
        chk("t5_ok_now", inst_sram_data_ok, 1);
        chk("t5_addr_ok_same", inst_sram_addr_ok, 1);
        q_inst.push_back('{wr: 1'b0, d: 32'hCAFE_0002});
        cyc();
        inst_sram_req = 0;
        serve_r(4'd0, 32'h1C00_0020, 3'd2, 32'hCAFE_0002);
        cyc();

        // reset while in R_R
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
        cyc();
        inst_sram_req = 0;
        cyc();
        chk("t6_in_rr", rready, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("t6_rready", rready, 0);
        chk("t6_arvalid", arvalid, 0);
        chk("t6_araddr", araddr, 0);
        chk("t6_inst_ok", inst_sram_data_ok, 0);
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        cyc();
        cyc();
        rvalid = 0;
        chk("t6_no_late_ok", inst_sram_data_ok, 0);

        // reset while in W_REQ
        data_sram_req = 1; data_sram_wr = 1;
        data_sram_addr = 32'h0000_2000; data_sram_wdata = 32'h7777_8888;
        awready = 0; wready = 0;
        cyc();
        data_sram_req = 0;
        chk("t7_awvalid", awvalid, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("t7_awvalid_rst", awvalid, 0);
        chk("t7_wvalid_rst", wvalid, 0);
        chk("t7_bready_rst", bready, 0);
        chk("t7_awaddr_rst", awaddr, 0);
        chk("t7_wdata_rst", wdata, 0);
        bvalid = 1;
        cyc();
        cyc();
        bvalid = 0;
        chk("t7_no_late_ok", data_sram_data_ok, 0);

        repeat (3) cyc();
        chk("end_inst_q_empty", q_inst.size(), 0);
        chk("end_data_q_empty", q_data.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
